seq_divider_8bit: RTL
=====================

// Module: seq_divider_8bit
// PURPOSE
//  Multi-cycle restoring divider: quotient and remainder of two WIDTH-bit operands, one bit per clock.
//  Uses the same trial-subtract datapath as the add/sub unit (A + ~B + 1).
//  Sits beside the adder as the ALU's long-latency div/mod unit, driven by a start/done handshake.
// PARAMETERS
//  WIDTH  8  operand, quotient and remainder width in bits (>= 2)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous reset, active low
//  start        in   1      request; sampled only when busy=0
//  dividend     in   WIDTH  numerator, captured on the accepted start
//  divisor      in   WIDTH  denominator, captured on the accepted start
//  busy         out  1      high while in RUN or FIX
//  done         out  1      one-cycle pulse; results valid from this cycle
//  quotient     out  WIDTH  result; held until the next accepted start
//  remainder    out  WIDTH  result; held until the next accepted start
//  div_by_zero  out  1      set with done when divisor==0; held like results
// BEHAVIOUR
//  - Reset: rst_n low at a posedge -> state IDLE; busy, done, quotient, remainder and div_by_zero all 0.
//    Applies mid-operation too; the in-flight division is discarded and done never pulses.
//  - States:
//    IDLE -start-> RUN, or DONE if divisor==0.
//    RUN: WIDTH iterations -> DONE, or FIX when SIGNED_DIV_EN.
//    FIX -> DONE.
//    DONE -> IDLE, or RUN/DONE when start is high in DONE.
//  - busy=0 in IDLE and DONE, so a start in the DONE cycle is accepted back-to-back.
//    start while busy=1 is ignored; no queuing.
//  - Capture on start: quo<=dividend, rem (WIDTH+1 bits)<=0, dsr<=divisor, counter<=0.
//  - Each RUN cycle:
//    {rem,quo} <<= 1;
//    t = rem - {1'b0,dsr};
//    if t[WIDTH]==0: rem=t, quo[0]=1; else rem is kept and quo[0]=0.
//    counter increments; leave RUN when counter==WIDTH-1.
//  - Latency, unsigned: start sampled at edge 0; done high during cycle WIDTH+1 (9 for WIDTH=8).
//  - Divide by zero: detected at the start edge; done high at cycle 1, with
//    div_by_zero=1, quotient={WIDTH{1}}, remainder=dividend.
//  - Outputs quotient/remainder/div_by_zero update only on entry to DONE.
//  - div_by_zero is cleared on the next accepted start.
//  - Dividend < divisor gives quotient 0, remainder=dividend. No other error conditions.
// CONFIGURATION
//  SIGNED_DIV_EN defined:
//    - Operands are two's complement and are converted to magnitudes at capture.
//    - An extra FIX cycle negates the quotient if the operand signs differ.
//    - The remainder takes the sign of the dividend (truncating division).
//    - Latency WIDTH+2.
//    - Most-negative / -1 wraps: quotient=8'h80, remainder 0, no flag.
//    - Divide by zero unchanged (latency 1, quotient all ones, remainder=dividend).
//  SIGNED_DIV_EN undefined:
//    - Unsigned only, FIX state absent, latency WIDTH+1.
// TESTING
//  1. 100/7 unsigned -> done at cycle 9; quotient=14 (8'h0E), remainder=2, div_by_zero=0; busy high cycles 1-8.
//  2. 255/1 -> quotient=8'hFF, remainder=0; then 3/200 -> quotient=0, remainder=3.
//  3. 5/0 -> done at cycle 1; div_by_zero=1, quotient=8'hFF, remainder=8'h05; next start 6/3 clears flag, quotient=2.
//  4. start 50/5; pulse start 9/3 at cycle 4 -> ignored; done at cycle 9 with quotient=10, remainder=0.
//     Then start in the DONE cycle with 9/3 -> accepted; done at cycle 18 with quotient=3.
//  5. start 200/3; rst_n low at cycle 5 -> cycle 6 all outputs 0; no done pulse; a new 8/2 after reset -> quotient=4.
//  6. SIGNED_DIV_EN: -100/7 -> done at cycle 10, quotient=8'hF2 (-14), remainder=8'hFE (-2); -128/-1 -> quotient=8'h80, remainder=0.

Source files
------------

// File: rtl/seq_divider_8bit.sv
// Multi-cycle restoring divider (one quotient bit per clock) with start/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (magnitude divide plus a sign-fix cycle).
module seq_divider_8bit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] quo, dsr, rem;
   logic [CNT_W-1:0] count;
   logic             accept, last, zero_div;
   logic [WIDTH:0]   rem_sh, trial;
   logic [WIDTH-1:0] quo_nxt, rem_nxt;
   logic [WIDTH-1:0] mag_a, mag_b;
`ifdef SIGNED_DIV_EN
   logic             neg_q, neg_r;
`endif

   assign accept   = start && !busy;
   assign last     = (count == CNT_W'(WIDTH - 1));
   assign zero_div = (divisor == '0);

`ifdef SIGNED_DIV_EN
   assign mag_a = dividend[WIDTH-1] ? -dividend : dividend;
   assign mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
   assign mag_a = dividend;
   assign mag_b = divisor;
`endif

   // Stored remainder never exceeds the divisor, so only the shifted trial value needs WIDTH+1 bits.
   always_comb begin
      rem_sh  = {rem, quo[WIDTH-1]};
      trial   = rem_sh - {1'b0, dsr};
      rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = zero_div ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
`ifdef SIGNED_DIV_EN
            if (last) state_nxt = FIX;
`else
            if (last) state_nxt = DONE;
`endif
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = zero_div ? DONE : RUN;
            else       state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quo         <= '0;
         rem         <= '0;
         dsr         <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else if (accept) begin
         quo         <= mag_a;
         rem         <= '0;
         dsr         <= mag_b;
         count       <= '0;
         div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         neg_r       <= dividend[WIDTH-1];
`endif
         if (zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         quo   <= quo_nxt;
         rem   <= rem_nxt;
         count <= count + 1'b1;
`ifndef SIGNED_DIV_EN
         if (last) begin
            quotient  <= quo_nxt;
            remainder <= rem_nxt;
         end
`endif
      end
`ifdef SIGNED_DIV_EN
      else if (state == FIX) begin
         quotient  <= neg_q ? -quo : quo;
         remainder <= neg_r ? -rem : rem;
      end
`endif
   end

endmodule
